// File: rtl/led_pkg.sv
// Shared types and default sizing for the LED bank arbiter.
package led_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_e;

    localparam int LED_NREQ  = 4;
    localparam int LED_WIDTH = 8;
    localparam int LED_DWELL = 16;

endpackage

// File: rtl/led_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of (req & mask)
// searching upward from a start index, with wrap.
module rr_pick
    import led_pkg::*;
#(
    parameter int NREQ = LED_NREQ
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [NREQ-1:0]         mask_i,
    input  logic [$clog2(NREQ)-1:0] start_i,
    output logic [NREQ-1:0]         pick_o,
    output logic                    valid_o
);

    localparam int PW = $clog2(NREQ);

    logic [NREQ-1:0] eff;
    logic [PW-1:0]   idx;

    assign eff = req_i & mask_i;

    always_comb begin
        pick_o  = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = PW'((int'(start_i) + i) % NREQ);
            if (!valid_o && eff[idx]) begin
                pick_o[idx] = 1'b1;
                valid_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_arbiter.sv
// Round-robin owner of the LED bank with per-grant tick dwell.
// Define LED_ARB_PRIORITY_EN to let requester 0 preempt other owners.
module led_arbiter
    import led_pkg::*;
#(
    parameter int NREQ  = LED_NREQ,
    parameter int WIDTH = LED_WIDTH,
    parameter int DWELL = LED_DWELL
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  tick,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] data,
    output logic [NREQ-1:0]       grant,
    output logic [WIDTH-1:0]      leds,
    output logic                  busy
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(DWELL + 1);

    state_e            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [WIDTH-1:0]  leds_q, leds_d;
    logic              busy_q;

    logic [PW-1:0]     owner;
    logic [PW-1:0]     next_ptr;
    logic [PW-1:0]     pick_idx;
    logic [WIDTH-1:0]  own_data;
    logic [WIDTH-1:0]  pick_data;
    logic              drop;
    logic              expire;
    logic              rel;
    logic              preempt;
    logic [PW-1:0]     pk_start;
    logic [NREQ-1:0]   pk_mask;
    logic [NREQ-1:0]   pick;
    logic              pick_vld;

    always_comb begin
        owner    = '0;
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) owner = PW'(i);
            if (pick[i])    pick_idx = PW'(i);
        end
    end

    assign next_ptr  = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
    assign own_data  = data[owner*WIDTH +: WIDTH];
    assign pick_data = data[pick_idx*WIDTH +: WIDTH];

    assign drop   = (state_q == OWN) && !req[owner];
    assign expire = tick && (cnt_q == CW'(DWELL - 1));
    assign rel    = drop || expire;

`ifdef LED_ARB_PRIORITY_EN
    assign preempt = (state_q == OWN) && req[0] && !grant_q[0];
`else
    assign preempt = 1'b0;
`endif

    // One picker serves both the idle grant and the release handover.
    assign pk_start = (state_q == OWN) ? next_ptr : ptr_q;
    assign pk_mask  = drop ? ~grant_q : '1;

    rr_pick #(
        .NREQ(NREQ)
    ) u_pick (
        .req_i  (req),
        .mask_i (pk_mask),
        .start_i(pk_start),
        .pick_o (pick),
        .valid_o(pick_vld)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        leds_d  = leds_q;
        unique case (state_q)
            IDLE: begin
                grant_d = '0;
                leds_d  = '0;
                if (pick_vld) begin
                    state_d = OWN;
                    grant_d = pick;
                    leds_d  = pick_data;
                    cnt_d   = '0;
                end
            end
            OWN: begin
                if (preempt) begin
                    grant_d = NREQ'(1);
                    leds_d  = data[0 +: WIDTH];
                    cnt_d   = '0;
                end else if (rel) begin
                    ptr_d = next_ptr;
                    cnt_d = '0;
                    if (pick_vld) begin
                        grant_d = pick;
                        leds_d  = pick_data;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        leds_d  = '0;
                    end
                end else begin
                    leds_d = own_data;
                    if (tick) cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            leds_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            leds_q  <= leds_d;
            busy_q  <= |grant_d;
        end
    end

    assign grant = grant_q;
    assign leds  = leds_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_led_arbiter.sv
// Scoreboard bench for led_arbiter: stimulus queues expected grant
// changes, a negedge monitor pops and compares them.
module tb_led_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int DWELL = 4;

    typedef struct {
        logic [NREQ-1:0]  g;
        logic [WIDTH-1:0] l;
        int               t;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic                  tick;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] data;
    logic [NREQ-1:0]       grant;
    logic [WIDTH-1:0]      leds;
    logic                  busy;

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];

    led_arbiter #(
        .NREQ (NREQ),
        .WIDTH(WIDTH),
        .DWELL(DWELL)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .tick (tick),
        .req  (req),
        .data (data),
        .grant(grant),
        .leds (leds),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [NREQ-1:0] g,
                        input logic [WIDTH-1:0] l, input int t);
        exp_t e;
        e.g = g;
        e.l = l;
        e.t = t;
        q.push_back(e);
    endtask

    task automatic clk1(input logic t);
        @(posedge clk);
        #1 tick = t;
    endtask

    task automatic tk(input int n);
        repeat (n) begin
            clk1(1'b0);
            clk1(1'b0);
            clk1(1'b0);
            clk1(1'b0);
            clk1(1'b1);
        end
    endtask

    // Monitor: per-cycle invariants plus scoreboard on grant changes.
    logic [NREQ-1:0]       prev_g = '0;
    logic                  pend_t = 1'b0;
    logic [NREQ*WIDTH-1:0] prev_d = '0;
    int                    seen   = 0;

    always @(negedge clk) begin
        int   oi;
        exp_t e;
        if (pend_t) seen++;
        oi = 0;
        for (int i = 0; i < NREQ; i++) if (grant[i]) oi = i;
        chk("busy", 32'(busy), 32'(|grant));
        chk("onehot", 32'($countones(grant) <= 1), 32'(1));
        if (grant != '0)
            chk("leds_own", 32'(leds), 32'(prev_d[oi*WIDTH +: WIDTH]));
        else
            chk("leds_idle", 32'(leds), 32'(0));
        if (grant != prev_g) begin
            if (q.size() == 0) begin
                chk("unexpected_grant", 32'(grant), 32'(prev_g));
            end else begin
                e = q.pop_front();
                chk("sb_grant", 32'(grant), 32'(e.g));
                chk("sb_leds", 32'(leds), 32'(e.l));
                if (e.t >= 0) chk("sb_ticks", 32'(seen), 32'(e.t));
            end
            seen = 0;
        end
        prev_g = grant;
        pend_t = tick;
        prev_d = data;
    end

    initial begin
        rstn = 1'b0;
        tick = 1'b0;
        req  = 4'b1111;
        data = {8'h88, 8'h44, 8'h22, 8'h11};

        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_grant", 32'(grant), 32'(0));
            chk("rst_leds", 32'(leds), 32'(0));
            chk("rst_busy", 32'(busy), 32'(0));
        end
        push(4'b0001, 8'h11, -1);
        rstn = 1'b1;
        clk1(1'b0);
        chk("first_grant", 32'(grant), 32'(4'b0001));

`ifndef LED_ARB_PRIORITY_EN
        // Rotation over all four sources.
        push(4'b0010, 8'h22, 4);
        push(4'b0100, 8'h44, 4);
        push(4'b1000, 8'h88, 4);
        push(4'b0001, 8'h11, 4);
        tk(16);
        clk1(1'b0);

        // Expiry hands 0 -> 2, then 2 drops after one tick.
        req = 4'b0101;
        push(4'b0100, 8'h44, 4);
        tk(4);
        clk1(1'b0);
        push(4'b0001, 8'h11, 1);
        tk(1);
        clk1(1'b0);
        req = 4'b0001;
        clk1(1'b0);
        chk("drop_grant", 32'(grant), 32'(4'b0001));

        // Sole requester keeps the bank across expiries.
        push(4'b0100, 8'h44, -1);
        req = 4'b0100;
        clk1(1'b0);
        for (int i = 0; i < 3 * DWELL; i++) begin
            data[23:16] = 8'(8'h50 + i);
            tk(1);
            chk("sole_grant", 32'(grant), 32'(4'b0100));
        end
        clk1(1'b0);
        data[23:16] = 8'h44;

        // Owner 1 drops on the same edge as its final tick.
        push(4'b0010, 8'h22, -1);
        req = 4'b0010;
        clk1(1'b0);
        req = 4'b0011;
        push(4'b0001, 8'h11, 4);
        tk(3);
        repeat (4) clk1(1'b0);
        @(posedge clk);
        #1;
        tick = 1'b1;
        req  = 4'b0001;
        clk1(1'b0);
        chk("simul_grant", 32'(grant), 32'(4'b0001));
        chk("simul_ptr", 32'(dut.ptr_q), 32'(2));

        push(4'b0000, 8'h00, -1);
        req = 4'b0000;
        clk1(1'b0);
        chk("idle_grant", 32'(grant), 32'(0));
        chk("idle_leds", 32'(leds), 32'(0));
        chk("idle_busy", 32'(busy), 32'(0));
`else
        // Requester 0 preempts owner 3; ptr stays put.
        push(4'b0000, 8'h00, -1);
        req = 4'b0000;
        clk1(1'b0);
        push(4'b1000, 8'h88, -1);
        req = 4'b1000;
        clk1(1'b0);
        push(4'b0001, 8'h11, -1);
        req = 4'b1001;
        clk1(1'b0);
        chk("pre_grant", 32'(grant), 32'(4'b0001));
        chk("pre_ptr", 32'(dut.ptr_q), 32'(1));
        push(4'b1000, 8'h88, -1);
        req = 4'b1000;
        clk1(1'b0);
        chk("post_grant", 32'(grant), 32'(4'b1000));
`endif

        repeat (4) clk1(1'b0);
        chk("sb_drained", 32'(q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
